// File: rtl/oled_frame_arbiter.sv
// Frame-synchronous arbiter sharing one OLED pixel stream among N_SRC sources.
// Ownership changes only on a frame_begin rising edge, so a frame never tears.
module oled_src_lane (
  input  logic        sel,
  input  logic [15:0] data,
  output logic [15:0] masked
);
  assign masked = sel ? data : 16'h0000;
endmodule

module oled_frame_arbiter #(
  parameter int          N_SRC       = 4,
  parameter int          HOLD_FRAMES = 2,
  parameter logic [15:0] BG_COLOR    = 16'h0000
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  frame_begin,
  input  logic                  rr_en,
  input  logic [N_SRC-1:0]      req,
  input  logic [16*N_SRC-1:0]   src_pixel_data,
  output logic [15:0]           pixel_data,
  output logic [N_SRC-1:0]      grant,
  output logic [N_SRC-1:0]      frame_done,
  output logic                  busy
);
  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic {IDLE, SHOW} state_t;

  state_t           state, state_n;
  logic [N_SRC-1:0] grant_n, done_n;
  logic [IW-1:0]    gidx, gidx_n, last_grant, last_n, win_idx;
  logic [7:0]       frame_cnt, cnt_n, cnt_inc;
  logic             frame_begin_d, fb_evt, win_ok, hold_over;

  assign fb_evt    = frame_begin & ~frame_begin_d;
  assign cnt_inc   = (frame_cnt == 8'hFF) ? frame_cnt : frame_cnt + 8'd1;
  assign hold_over = ({1'b0, frame_cnt} + 9'd1) >= 9'(HOLD_FRAMES);

  // Round-robin scans from last_grant+1; descending loop leaves the nearest hit,
  // so the current owner is only re-picked when it is the sole requester.
  always_comb begin
    int j;
    j       = 0;
    win_ok  = 1'b0;
    win_idx = '0;
    if (!rr_en) begin
      for (int i = N_SRC-1; i >= 0; i--)
        if (req[i]) begin
          win_ok  = 1'b1;
          win_idx = IW'(i);
        end
    end else begin
      for (int k = N_SRC; k >= 1; k--) begin
        j = (int'(last_grant) + k) % N_SRC;
        if (req[j]) begin
          win_ok  = 1'b1;
          win_idx = IW'(j);
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    gidx_n  = gidx;
    last_n  = last_grant;
    cnt_n   = frame_cnt;
    done_n  = '0;
    case (state)
      IDLE: if (fb_evt && win_ok) begin
        state_n          = SHOW;
        grant_n          = '0;
        grant_n[win_idx] = 1'b1;
        gidx_n           = win_idx;
        last_n           = win_idx;
        cnt_n            = 8'd0;
      end
      SHOW: if (fb_evt) begin
        done_n[gidx] = 1'b1;
        cnt_n        = cnt_inc;
        if (!req[gidx] || hold_over) begin
          if (win_ok) begin
            grant_n          = '0;
            grant_n[win_idx] = 1'b1;
            gidx_n           = win_idx;
            last_n           = win_idx;
            cnt_n            = 8'd0;
          end else begin
            state_n = IDLE;
            grant_n = '0;
            cnt_n   = 8'd0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant         <= '0;
      gidx          <= '0;
      last_grant    <= IW'(N_SRC-1);
      frame_cnt     <= 8'd0;
      frame_done    <= '0;
      frame_begin_d <= 1'b0;
    end else begin
      state         <= state_n;
      grant         <= grant_n;
      gidx          <= gidx_n;
      last_grant    <= last_n;
      frame_cnt     <= cnt_n;
      frame_done    <= done_n;
      frame_begin_d <= frame_begin;
    end
  end

  assign busy = (state == SHOW);

  logic [N_SRC-1:0][15:0] lane_px;
  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_lane
      oled_src_lane u_lane (
        .sel    (grant[gi]),
        .data   (src_pixel_data[16*gi +: 16]),
        .masked (lane_px[gi])
      );
    end
  endgenerate

  always_comb begin
    logic [15:0] acc;
    acc = 16'h0000;
    for (int i = 0; i < N_SRC; i++) acc = acc | lane_px[i];
    pixel_data = busy ? acc : BG_COLOR;
  end
endmodule

// File: tb/tb_oled_frame_arbiter.sv
// Directed bench: HOLD_FRAMES=2 instance for priority/hold/release/edge cases,
// HOLD_FRAMES=1 instance for round-robin rotation and reset recovery.
module tb_oled_frame_arbiter;
  logic        clock = 1'b0;
  logic        rst_n, frame_begin, rr_en;
  logic [3:0]  req;
  logic [63:0] src_pixel_data;
  logic [15:0] pixel_data, pixel_data1;
  logic [3:0]  grant, frame_done, grant1, frame_done1;
  logic        busy, busy1;
  int          errors = 0, checks = 0;

  always #5 clock = ~clock;

  oled_frame_arbiter #(.N_SRC(4), .HOLD_FRAMES(2), .BG_COLOR(16'h0000)) u_dut (
    .clock(clock), .rst_n(rst_n), .frame_begin(frame_begin), .rr_en(rr_en),
    .req(req), .src_pixel_data(src_pixel_data), .pixel_data(pixel_data),
    .grant(grant), .frame_done(frame_done), .busy(busy));

  oled_frame_arbiter #(.N_SRC(4), .HOLD_FRAMES(1), .BG_COLOR(16'h0000)) u_dut1 (
    .clock(clock), .rst_n(rst_n), .frame_begin(frame_begin), .rr_en(rr_en),
    .req(req), .src_pixel_data(src_pixel_data), .pixel_data(pixel_data1),
    .grant(grant1), .frame_done(frame_done1), .busy(busy1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // raise frame_begin; returns one clock later with grant/frame_done updated
  task automatic fb_rise();
    frame_begin = 1'b1;
    tick();
  endtask

  task automatic fb_fall();
    frame_begin = 1'b0;
    repeat (3) tick();
  endtask

  always @(negedge clock)
    if (rst_n !== 1'bx) chk("onehot", {31'b0, $onehot0(grant) && $onehot0(grant1)}, 32'd1);

  initial begin
    int pulses, changes;
    logic [3:0] prev;
    src_pixel_data = {16'h001F, 16'hF800, 16'h07E0, 16'h1234};
    rst_n = 1'b0; frame_begin = 1'b1; rr_en = 1'b0; req = 4'b1111;
    repeat (2) tick();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_pix", pixel_data, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", frame_done, 4'b0000);

    rst_n = 1'b1;
    tick();
    chk("first_grant", grant, 4'b0001);
    chk("first_pix", pixel_data, 16'h1234);
    chk("first_busy", busy, 1'b1);
    chk("first_done", frame_done, 4'b0000);
    fb_fall();

    // drop everything: back to idle
    req = 4'b0000;
    fb_rise();
    chk("idle_grant", grant, 4'b0000);
    chk("idle_done", frame_done, 4'b0001);
    chk("idle_busy", busy, 1'b0);
    fb_fall();

    // fixed priority with hold
    req = 4'b0100;
    fb_rise();
    chk("fp_grant", grant, 4'b0100);
    chk("fp_pix", pixel_data, 16'hF800);
    fb_fall();
    req = 4'b0101;
    tick();
    chk("fp_midframe", grant, 4'b0100);
    fb_rise();
    chk("fp_hold_grant", grant, 4'b0100);
    chk("fp_hold_done", frame_done, 4'b0100);
    fb_fall();
    chk("fp_done_clr", frame_done, 4'b0000);
    fb_rise();
    chk("fp_switch_grant", grant, 4'b0001);
    chk("fp_switch_done", frame_done, 4'b0100);
    chk("fp_switch_pix", pixel_data, 16'h1234);
    fb_fall();

    // edge detection: long frame_begin level, req[0] dropped -> release to src 2
    req = 4'b0100;
    frame_begin = 1'b1;
    pulses = 0; changes = 0; prev = grant;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (frame_done != 4'b0000) pulses++;
      if (grant != prev) changes++;
      prev = grant;
    end
    chk("edge_pulses", pulses, 1);
    chk("edge_changes", changes, 1);
    chk("edge_grant", grant, 4'b0100);
    fb_fall();

    // early release of source 1
    req = 4'b0010;
    fb_rise();
    chk("er_grant", grant, 4'b0010);
    fb_fall();
    req = 4'b0000;
    tick();
    chk("er_hold", grant, 4'b0010);
    chk("er_hold_busy", busy, 1'b1);
    fb_rise();
    chk("er_grant_off", grant, 4'b0000);
    chk("er_busy", busy, 1'b0);
    chk("er_pix", pixel_data, 16'h0000);
    chk("er_done", frame_done, 4'b0010);
    fb_fall();

    // round robin, HOLD_FRAMES=1 instance
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1; rr_en = 1'b1; req = 4'b1011;
    tick();
    fb_rise();
    chk("rr1_grant", grant1, 4'b0001);
    chk("rr1_done", frame_done1, 4'b0000);
    chk("rr1_hold2", grant, 4'b0001);
    fb_fall();
    fb_rise();
    chk("rr2_grant", grant1, 4'b0010);
    chk("rr2_done", frame_done1, 4'b0001);
    chk("rr2_hold2", grant, 4'b0001);
    fb_fall();
    fb_rise();
    chk("rr3_grant", grant1, 4'b1000);
    chk("rr3_done", frame_done1, 4'b0010);
    chk("rr3_hold2", grant, 4'b0010);
    chk("rr3_pix", pixel_data1, 16'h001F);
    fb_fall();
    fb_rise();
    chk("rr4_grant", grant1, 4'b0001);
    chk("rr4_done", frame_done1, 4'b1000);
    fb_fall();
    // sole requester re-granted
    req = 4'b0001;
    fb_rise();
    chk("rr_self_grant", grant1, 4'b0001);
    chk("rr_self_done", frame_done1, 4'b0001);
    fb_fall();

    // mid-operation asynchronous reset
    req = 4'b1011;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_grant", grant1, 4'b0000);
    chk("ar_busy", busy1, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    fb_rise();
    chk("ar_recover", grant1, 4'b0001);
    fb_fall();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
